// File: rtl/imm_pkg.sv
// imm_pkg: shared constants for the immediate encoder.
//   - immediate-type select encodings (I/S/B/U/J)
//   - result error codes
//   - bit positions inside F = inst[31:7] (F[i] = inst[i+7])
//   - a small helper that classifies a select value as legal or not
package imm_pkg;

    // Immediate-type select values
    localparam logic [2:0] IMM_SEL_I = 3'd1;
    localparam logic [2:0] IMM_SEL_S = 3'd2;
    localparam logic [2:0] IMM_SEL_B = 3'd3;
    localparam logic [2:0] IMM_SEL_U = 3'd4;
    localparam logic [2:0] IMM_SEL_J = 3'd5;

    // Error codes reported alongside each result
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_SEL   = 2'd3;

    // Field positions within F (inst[31:7])
    localparam int F_MSB      = 24;  // inst[31]
    localparam int F_I_LO     = 13;  // I: F[24:13] = imm[11:0]
    localparam int F_SB_HI_LO = 18;  // S/B upper chunk ends at F[18]
    localparam int F_SB_LO_HI = 4;   // S/B lower chunk F[4:0] / F[4:1]
    localparam int F_B_BIT11  = 0;   // B: imm[11] lives in F[0] (inst[7])
    localparam int F_U_LO     = 5;   // U: F[24:5] = imm[31:12]
    localparam int F_J_LO_HI  = 23;  // J: F[23:14] = imm[10:1]
    localparam int F_J_LO_LO  = 14;
    localparam int F_J_BIT11  = 13;  // J: F[13] = imm[11]
    localparam int F_J_MID_HI = 12;  // J: F[12:5] = imm[19:12]
    localparam int F_J_MID_LO = 5;

    // True for the five encodable immediate types
    function automatic logic sel_legal(input logic [2:0] sel);
        return (sel >= IMM_SEL_I) && (sel <= IMM_SEL_J);
    endfunction

endpackage

// File: rtl/imm_enc_core.sv
// imm_enc_core: combinational immediate scatter and legality checker.
//   Takes an immediate, a type select and the non-immediate instruction bits,
//   and produces inst[31:7] with the immediate scattered into its RISC-V
//   positions.  Any failed check returns the base bits untouched.
// Ports:
//   imm   in  XLEN  immediate (two's complement)
//   sel   in  3     immediate type (1=I 2=S 3=B 4=U 5=J)
//   base  in  INST  non-immediate bits to merge
//   field out INST  encoded inst[31:7]
//   err   out 1     encoding failed
//   code  out 2     error code (none/range/misaligned/illegal select)
module imm_enc_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int INST = 25
) (
    input  logic [XLEN-1:0] imm,
    input  logic [2:0]      sel,
    input  logic [INST-1:0] base,
    output logic [INST-1:0] field,
    output logic            err,
    output logic [1:0]      code
);

    logic [INST-1:0] enc;
    logic            sext_11;   // imm fits in 12-bit signed (I/S)
    logic            sext_12;   // imm fits in 13-bit signed (B)
    logic            sext_20;   // imm fits in 21-bit signed (J)

    // A value fits in N+1 signed bits when all bits from N upward agree.
    always_comb begin
        sext_11 = (&imm[XLEN-1:11]) | ~(|imm[XLEN-1:11]);
        sext_12 = (&imm[XLEN-1:12]) | ~(|imm[XLEN-1:12]);
        sext_20 = (&imm[XLEN-1:20]) | ~(|imm[XLEN-1:20]);
    end

    always_comb begin
        enc  = base;
        code = ERR_NONE;
        case (sel)
            IMM_SEL_I: begin
                enc[F_MSB:F_I_LO] = imm[11:0];
                if (!sext_11) code = ERR_RANGE;
            end
            IMM_SEL_S: begin
                enc[F_MSB:F_SB_HI_LO] = imm[11:5];
                enc[F_SB_LO_HI:0]     = imm[4:0];
                if (!sext_11) code = ERR_RANGE;
            end
            IMM_SEL_B: begin
                enc[F_MSB]              = imm[12];
                enc[F_MSB-1:F_SB_HI_LO] = imm[10:5];
                enc[F_SB_LO_HI:1]       = imm[4:1];
                enc[F_B_BIT11]          = imm[11];
                if (imm[0])        code = ERR_ALIGN;
                else if (!sext_12) code = ERR_RANGE;
            end
            IMM_SEL_U: begin
                enc[F_MSB:F_U_LO] = imm[31:12];
                if (imm[11:0] != 12'd0) code = ERR_ALIGN;
            end
            IMM_SEL_J: begin
                enc[F_MSB]                 = imm[20];
                enc[F_J_LO_HI:F_J_LO_LO]   = imm[10:1];
                enc[F_J_BIT11]             = imm[11];
                enc[F_J_MID_HI:F_J_MID_LO] = imm[19:12];
                if (imm[0])        code = ERR_ALIGN;
                else if (!sext_20) code = ERR_RANGE;
            end
            default: begin
                code = ERR_SEL;
            end
        endcase

        // Belt and braces: an unlisted select can never leak a partial scatter.
        if (!sel_legal(sel)) code = ERR_SEL;

        err   = (code != ERR_NONE);
        field = err ? base : enc;
    end

endmodule

// File: rtl/imm_enc.sv
// imm_enc: two-stage valid/ready immediate encoder with result statistics.
//   S1 holds the accepted request (imm, sel, base); the combinational core
//   sits between S1 and S2; S2 holds the registered result.  Each stage
//   reloads when empty or when its contents leave in the same cycle, so the
//   pipe sustains one result per cycle and holds at most two entries when
//   the consumer stalls.
// Ports:
//   clk_i           in   clock
//   rst_i           in   synchronous active-high reset
//   in_valid_i      in   request valid
//   in_ready_o      out  request accepted when in_valid_i && in_ready_o
//   in_imm_i        in   XLEN immediate
//   in_sel_i        in   3-bit immediate type select
//   in_base_i       in   INST non-immediate bits
//   out_valid_o     out  result valid
//   out_ready_i     in   consumer ready
//   out_field_o     out  encoded inst[31:7]
//   out_err_o       out  encoding failed
//   out_err_code_o  out  error code
//   cnt_clr_i       in   synchronous clear of both counters
//   enc_cnt_o       out  successful results delivered (saturating)
//   err_cnt_o       out  errored results delivered (saturating)
module imm_enc
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int INST  = 25,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  in_imm_i,
    input  logic [2:0]       in_sel_i,
    input  logic [INST-1:0]  in_base_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [INST-1:0]  out_field_o,
    output logic             out_err_o,
    output logic [1:0]       out_err_code_o,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] enc_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    logic            s1_v;
    logic [XLEN-1:0] s1_imm;
    logic [2:0]      s1_sel;
    logic [INST-1:0] s1_base;

    logic            s2_v;
    logic [INST-1:0] s2_field;
    logic            s2_err;
    logic [1:0]      s2_code;

    logic [INST-1:0] core_field;
    logic            core_err;
    logic [1:0]      core_code;

    logic s1_load;
    logic s2_load;
    logic out_hs;

    logic [CNT_W-1:0] enc_cnt;
    logic [CNT_W-1:0] err_cnt;

    // S2 can take new data if empty or draining this cycle; S1 can if empty
    // or if its entry moves into S2.  S1's load condition is the upstream
    // ready, which reduces to !s1_v || !s2_v || out_ready_i.
    assign s2_load    = !s2_v || out_ready_i;
    assign s1_load    = !s1_v || s2_load;
    assign in_ready_o = s1_load;
    assign out_hs     = s2_v && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v    <= 1'b0;
            s1_imm  <= '0;
            s1_sel  <= '0;
            s1_base <= '0;
        end else if (s1_load) begin
            s1_v <= in_valid_i;
            if (in_valid_i) begin
                s1_imm  <= in_imm_i;
                s1_sel  <= in_sel_i;
                s1_base <= in_base_i;
            end
        end
    end

    imm_enc_core #(
        .XLEN (XLEN),
        .INST (INST)
    ) u_core (
        .imm   (s1_imm),
        .sel   (s1_sel),
        .base  (s1_base),
        .field (core_field),
        .err   (core_err),
        .code  (core_code)
    );

    // Result registers only move when S2 reloads, which keeps the outputs
    // frozen while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_v     <= 1'b0;
            s2_field <= '0;
            s2_err   <= 1'b0;
            s2_code  <= ERR_NONE;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_field <= core_field;
                s2_err   <= core_err;
                s2_code  <= core_code;
            end
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enc_cnt <= '0;
            err_cnt <= '0;
        end else if (cnt_clr_i) begin
            enc_cnt <= '0;
            err_cnt <= '0;
        end else if (out_hs) begin
            if (!s2_err) begin
                if (enc_cnt != '1) enc_cnt <= enc_cnt + CNT_W'(1);
            end else begin
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid_o    = s2_v;
    assign out_field_o    = s2_field;
    assign out_err_o      = s2_err;
    assign out_err_code_o = s2_code;
    assign enc_cnt_o      = enc_cnt;
    assign err_cnt_o      = err_cnt;

endmodule

// File: tb/tb_imm_enc.sv
// Scoreboard bench for imm_enc: the driver pushes each accepted request with
// its expected outcome; an independent monitor pops and checks on every
// output handshake.  Directed vectors carry hand-computed fields; random
// vectors are checked by decoding the field back and comparing to the
// original immediate.
module tb_imm_enc;

    localparam int XLEN  = 32;
    localparam int INST  = 25;
    localparam int CNT_W = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [XLEN-1:0]  in_imm_i;
    logic [2:0]       in_sel_i;
    logic [INST-1:0]  in_base_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [INST-1:0]  out_field_o;
    logic             out_err_o;
    logic [1:0]       out_err_code_o;
    logic             cnt_clr_i;
    logic [CNT_W-1:0] enc_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;

    always #5 clk_i = ~clk_i;

    imm_enc #(
        .XLEN  (XLEN),
        .INST  (INST),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_imm_i       (in_imm_i),
        .in_sel_i       (in_sel_i),
        .in_base_i      (in_base_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_field_o    (out_field_o),
        .out_err_o      (out_err_o),
        .out_err_code_o (out_err_code_o),
        .cnt_clr_i      (cnt_clr_i),
        .enc_cnt_o      (enc_cnt_o),
        .err_cnt_o      (err_cnt_o)
    );

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  sel;
        logic [24:0] base;
        bit          chk_field;
        logic [24:0] exp_field;
        logic [1:0]  exp_code;
    } entry_t;

    entry_t sb_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     auto_release = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic entry_t mk(input logic [31:0] imm, input logic [2:0] sel,
                                  input logic [24:0] base, input logic [24:0] f,
                                  input logic [1:0] code);
        entry_t e;
        e.imm = imm; e.sel = sel; e.base = base;
        e.chk_field = 1'b1; e.exp_field = f; e.exp_code = code;
        return e;
    endfunction

    // Immediate generator (the decode direction)
    function automatic logic [31:0] decode(input logic [24:0] f, input logic [2:0] sel);
        logic [31:0] r;
        r = '0;
        case (sel)
            3'd1: r = {{20{f[24]}}, f[24:13]};
            3'd2: r = {{20{f[24]}}, f[24:18], f[4:0]};
            3'd3: r = {{19{f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
            3'd4: r = {f[24:5], 12'b0};
            3'd5: r = {{11{f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [24:0] imm_mask(input logic [2:0] sel);
        case (sel)
            3'd1:       return 25'h1FFE000;
            3'd2, 3'd3: return 25'h1FC001F;
            3'd4, 3'd5: return 25'h1FFFFE0;
            default:    return 25'h0;
        endcase
    endfunction

    // Expected error code from signed numeric ranges
    function automatic logic [1:0] model_code(input logic [31:0] imm, input logic [2:0] sel);
        int s;
        s = $signed(imm);
        case (sel)
            3'd1, 3'd2: return (s < -2048 || s > 2047) ? 2'd1 : 2'd0;
            3'd3: begin
                if (imm[0]) return 2'd2;
                return (s < -4096 || s > 4095) ? 2'd1 : 2'd0;
            end
            3'd4: return (imm[11:0] != 12'd0) ? 2'd2 : 2'd0;
            3'd5: begin
                if (imm[0]) return 2'd2;
                return (s < -1048576 || s > 1048575) ? 2'd1 : 2'd0;
            end
            default: return 2'd3;
        endcase
    endfunction

    // Drive one request; push to scoreboard when the handshake is certain.
    task automatic send(input entry_t e);
        int guard;
        guard = 0;
        in_valid_i = 1'b1;
        in_imm_i   = e.imm;
        in_sel_i   = e.sel;
        in_base_i  = e.base;
        forever begin
            @(negedge clk_i);
            if (in_ready_o) break;
            guard++;
            if (guard > 100) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: in_ready_o stuck at 0, required 1");
                in_valid_i = 1'b0;
                return;
            end
            @(posedge clk_i); #1;
            if (auto_release) out_ready_i = 1'b1;
        end
        sb_q.push_back(e);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        out_ready_i = 1'b1;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk_i);
        check("drain_empty", sb_q.size(), 0);
        @(posedge clk_i); #1;
    endtask

    // Monitor
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_output: got field 0x%0h with nothing pending, required no output", out_field_o);
            end else begin
                entry_t e;
                logic [24:0] m;
                e = sb_q.pop_front();
                m = imm_mask(e.sel);
                check("err_code", out_err_code_o, e.exp_code);
                check("err_flag", out_err_o, (e.exp_code != 2'd0));
                if (e.chk_field)
                    check("field", out_field_o, e.exp_field);
                else if (e.exp_code != 2'd0)
                    check("field_is_base", out_field_o, e.base);
                else begin
                    check("roundtrip", decode(out_field_o, e.sel), e.imm);
                    check("base_kept", out_field_o & ~m, e.base & ~m);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        entry_t dir[$];
        entry_t e;
        int     k;

        rst_i = 1'b1; in_valid_i = 1'b0; in_imm_i = '0; in_sel_i = '0;
        in_base_i = '0; out_ready_i = 1'b0; cnt_clr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        @(negedge clk_i);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_field", out_field_o, 0);
        check("rst_err", out_err_o, 0);
        check("rst_code", out_err_code_o, 0);
        check("rst_enc_cnt", enc_cnt_o, 0);
        check("rst_err_cnt", err_cnt_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        @(posedge clk_i); #1;

        // Directed vectors
        dir.push_back(mk(32'hFFFFFFFF, 3'd1, 25'h0,       25'h1FFE000, 2'd0));
        dir.push_back(mk(32'h00000800, 3'd1, 25'h0ABCDEF, 25'h0ABCDEF, 2'd1));
        dir.push_back(mk(32'hFFFFF801, 3'd2, 25'h0,       25'h1000001, 2'd0));
        dir.push_back(mk(32'hFFFFF000, 3'd3, 25'h0,       25'h1000000, 2'd0));
        dir.push_back(mk(32'h00000002, 3'd3, 25'h0,       25'h0000002, 2'd0));
        dir.push_back(mk(32'h00000003, 3'd3, 25'h1555555, 25'h1555555, 2'd2));
        dir.push_back(mk(32'h00001000, 3'd3, 25'h0,       25'h0,       2'd1));
        dir.push_back(mk(32'h12345000, 3'd4, 25'h000001F, 25'h02468BF, 2'd0));
        dir.push_back(mk(32'h00000800, 3'd4, 25'h0,       25'h0,       2'd2));
        dir.push_back(mk(32'h000FFFFE, 3'd5, 25'h0,       25'h0FFFFE0, 2'd0));
        dir.push_back(mk(32'h00000003, 3'd5, 25'h0,       25'h0,       2'd2));
        dir.push_back(mk(32'h00100000, 3'd5, 25'h0,       25'h0,       2'd1));
        dir.push_back(mk(32'h00000000, 3'd0, 25'h0000123, 25'h0000123, 2'd3));
        dir.push_back(mk(32'h00000000, 3'd7, 25'h0000456, 25'h0000456, 2'd3));
        dir.push_back(mk(32'h00000003, 3'd6, 25'h0000789, 25'h0000789, 2'd3));
        out_ready_i = 1'b1;
        foreach (dir[i]) send(dir[i]);
        drain();

        // Backpressure: two held, third waits, all three drain back to back
        out_ready_i = 1'b0;
        send(mk(32'h1, 3'd1, 25'h0, 25'h0002000, 2'd0));
        send(mk(32'h2, 3'd1, 25'h0, 25'h0004000, 2'd0));
        e = mk(32'h3, 3'd1, 25'h0, 25'h0006000, 2'd0);
        in_valid_i = 1'b1; in_imm_i = e.imm; in_sel_i = e.sel; in_base_i = e.base;
        @(negedge clk_i);
        check("bp_ready_low", in_ready_o, 0);
        check("bp_valid_held", out_valid_o, 1);
        check("bp_field_held", out_field_o, 25'h0002000);
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_accept_on_release", in_ready_o, 1);
        check("bp_out1_valid", out_valid_o, 1);
        sb_q.push_back(e);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_out2_valid", out_valid_o, 1);
        @(negedge clk_i);
        check("bp_out3_valid", out_valid_o, 1);
        @(posedge clk_i); #1;
        drain();

        // Random round-trip with random stalls
        auto_release = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            e.imm = $urandom();
            k = int'($urandom_range(0, 31));
            e.imm = $signed(e.imm) >>> k;
            e.sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) e.imm[0] = 1'b0;
            if (e.sel == 3'd4 && $urandom_range(0, 1) == 0) e.imm[11:0] = 12'd0;
            e.base = 25'($urandom());
            e.chk_field = 1'b0;
            e.exp_field = '0;
            e.exp_code  = model_code(e.imm, e.sel);
            out_ready_i = ($urandom_range(0, 3) != 0);
            send(e);
            if ($urandom_range(0, 4) == 0) begin @(posedge clk_i); #1; end
        end
        auto_release = 1'b0;
        drain();

        // Counters (2-bit, saturating)
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        sb_q.delete();
        out_ready_i = 1'b1;
        for (int n = 0; n < 5; n++)
            send(mk(32'(n), 3'd1, 25'h0, 25'(n) << 13, 2'd0));
        drain();
        @(negedge clk_i);
        check("enc_cnt_sat", enc_cnt_o, 3);
        check("err_cnt_zero", err_cnt_o, 0);
        @(posedge clk_i); #1;

        send(mk(32'h0, 3'd0, 25'h55, 25'h55, 2'd3));
        drain();
        @(negedge clk_i);
        check("err_cnt_one", err_cnt_o, 1);
        @(posedge clk_i); #1;

        out_ready_i = 1'b0;
        send(mk(32'h0, 3'd7, 25'h66, 25'h66, 2'd3));
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        cnt_clr_i = 1'b1;
        @(posedge clk_i); #1;
        cnt_clr_i = 1'b0;
        @(negedge clk_i);
        check("clr_err_cnt", err_cnt_o, 0);
        check("clr_enc_cnt", enc_cnt_o, 0);
        @(posedge clk_i); #1;

        send(mk(32'h0, 3'd6, 25'h77, 25'h77, 2'd3));
        send(mk(32'h7FF, 3'd1, 25'h0, 25'h0FFE000, 2'd0));
        drain();
        @(negedge clk_i);
        check("post_clr_err_cnt", err_cnt_o, 1);
        check("post_clr_enc_cnt", enc_cnt_o, 1);
        @(posedge clk_i); #1;

        // Reset with two entries in flight
        out_ready_i = 1'b0;
        send(mk(32'h10, 3'd1, 25'h0, 25'h0020000, 2'd0));
        send(mk(32'h20, 3'd1, 25'h0, 25'h0040000, 2'd0));
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        sb_q.delete();
        @(negedge clk_i);
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_enc_cnt", enc_cnt_o, 0);
        check("midrst_err_cnt", err_cnt_o, 0);
        check("midrst_in_ready", in_ready_o, 1);
        out_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("midrst_no_ghost", out_valid_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
